// File: rtl/hazard_stall_controller.sv
// Load-use / branch-flush / mul-div stall sequencer for the 5-stage core.
// Optional perf counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_controller #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MD_TIMEOUT        = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_branch_taken,
    input  logic        md_start,
    input  logic        md_done,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        ex_hold,
    output logic        ex_mem_bubble,
    output logic        md_go,
    output logic        md_timeout,
    output logic [1:0]  state_dbg,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
);
    localparam int CW = $clog2(MD_TIMEOUT + 1);
    localparam logic [CW-1:0] LD_INIT = CW'(LOAD_STALL_CYCLES - 1);
    localparam logic [CW-1:0] MD_LAST = CW'(MD_TIMEOUT - 1);
    localparam logic [CW-1:0] ONE     = CW'(1);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LD_STALL = 2'b01,
        MD_WAIT  = 2'b10
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          set_timeout;
    logic          load_use;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            cnt        <= '0;
            md_timeout <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (set_timeout) md_timeout <= 1'b1;
        end
    end

    // Outputs are gated by rst_n so reset forces defaults even with live hazards.
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        set_timeout   = 1'b0;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_hold       = 1'b0;
        ex_mem_bubble = 1'b0;
        md_go         = 1'b0;
        if (rst_n) begin
            case (state)
                RUN: begin
                    if (ex_branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (md_start) begin
                        md_go         = 1'b1;
                        pc_write      = 1'b0;
                        if_id_write   = 1'b0;
                        ex_hold       = 1'b1;
                        ex_mem_bubble = 1'b1;
                        cnt_nx        = '0;
                        state_nx      = MD_WAIT;
                    end else if (load_use) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            cnt_nx   = LD_INIT;
                            state_nx = LD_STALL;
                        end
                    end
                end
                LD_STALL: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    cnt_nx       = cnt - ONE;
                    if (cnt <= ONE) state_nx = RUN;
                end
                MD_WAIT: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    cnt_nx      = cnt + ONE;
                    // md_done takes priority over a timeout landing on the same cycle
                    if (md_done) begin
                        state_nx = RUN;
                    end else if (cnt >= MD_LAST) begin
                        set_timeout = 1'b1;
                        state_nx    = RUN;
                    end else begin
                        ex_hold       = 1'b1;
                        ex_mem_bubble = 1'b1;
                    end
                end
                default: begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    assign state_dbg = state;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_q, flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 16'h0000;
            flush_q <= 16'h0000;
        end else begin
            if (!pc_write && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'h0001;
            if (if_id_flush && (flush_q != 16'hFFFF)) flush_q <= flush_q + 16'h0001;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = 16'h0000;
    assign flush_count  = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench: dut_a uses LOAD_STALL_CYCLES=1/MD_TIMEOUT=40, dut_b uses 3/4.
// Output bundle order: {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold, ex_mem_bubble, md_go}.
module tb_hazard_stall_controller;
    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_uses_rs2, ex_mem_read, ex_branch_taken, md_start, md_done;

    logic pw_a, iw_a, fl_a, bb_a, eh_a, mb_a, go_a, to_a;
    logic pw_b, iw_b, fl_b, bb_b, eh_b, mb_b, go_b, to_b;
    logic [1:0] st_a, st_b;
    logic [15:0] sc_a, fc_a, sc_b, fc_b;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    hazard_stall_controller #(.LOAD_STALL_CYCLES(1), .MD_TIMEOUT(40)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .md_start(md_start), .md_done(md_done),
        .pc_write(pw_a), .if_id_write(iw_a), .if_id_flush(fl_a), .id_ex_bubble(bb_a),
        .ex_hold(eh_a), .ex_mem_bubble(mb_a), .md_go(go_a), .md_timeout(to_a),
        .state_dbg(st_a), .stall_cycles(sc_a), .flush_count(fc_a));

    hazard_stall_controller #(.LOAD_STALL_CYCLES(3), .MD_TIMEOUT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .md_start(md_start), .md_done(md_done),
        .pc_write(pw_b), .if_id_write(iw_b), .if_id_flush(fl_b), .id_ex_bubble(bb_b),
        .ex_hold(eh_b), .ex_mem_bubble(mb_b), .md_go(go_b), .md_timeout(to_b),
        .state_dbg(st_b), .stall_cycles(sc_b), .flush_count(fc_b));

    logic [6:0] oa, ob;
    assign oa = {pw_a, iw_a, fl_a, bb_a, eh_a, mb_a, go_a};
    assign ob = {pw_b, iw_b, fl_b, bb_b, eh_b, mb_b, go_b};

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic uses2, mr, br, ms, md;
        logic [6:0] exp;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in;
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0; id_uses_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0; md_start = 1'b0; md_done = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        clr_in();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // hazard inputs all live during reset: outputs must still be defaults
        rst_n = 1'b0;
        id_rs1 = 5'd5; id_rs2 = 5'd6; ex_rd = 5'd5; id_uses_rs2 = 1'b1;
        ex_mem_read = 1'b1; ex_branch_taken = 1'b1; md_start = 1'b1; md_done = 1'b0;
        #2;
        chk("rst_out_a", 16'(oa), 16'h60);
        chk("rst_out_b", 16'(ob), 16'h60);
        chk("rst_state", 16'(st_a), 16'h0);
        chk("rst_timeout", 16'(to_a), 16'h0);
        chk("rst_stall_cnt", sc_a, 16'h0);
        tick();
        rst_n = 1'b1;
        clr_in();

        tbl[0] = '{5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1100000};
        tbl[1] = '{5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0001000};
        tbl[2] = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1100000};
        tbl[3] = '{5'd3, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0001000};
        tbl[4] = '{5'd3, 5'd7, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1100000};
        tbl[5] = '{5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1100000};
        tbl[6] = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b1111000};
        tbl[7] = '{5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 7'b1111000};
        tbl[8] = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b1100000};
        tbl[9] = '{5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0001000};

        for (int i = 0; i < 10; i++) begin
            id_rs1 = tbl[i].rs1; id_rs2 = tbl[i].rs2; ex_rd = tbl[i].rd;
            id_uses_rs2 = tbl[i].uses2; ex_mem_read = tbl[i].mr;
            ex_branch_taken = tbl[i].br; md_start = tbl[i].ms; md_done = tbl[i].md;
            #3;
            chk($sformatf("vec%0d_out", i), 16'(oa), 16'(tbl[i].exp));
            chk($sformatf("vec%0d_state", i), 16'(st_a), 16'h0);
            tick();
        end
        clr_in();
        #3;
        chk("after_vec_state", 16'(st_a), 16'h0);

        // 3-cycle load stall on dut_b, 1-cycle on dut_a
        do_reset();
        id_rs2 = 5'd7; ex_rd = 5'd7; id_uses_rs2 = 1'b1; ex_mem_read = 1'b1; id_rs1 = 5'd1;
        #3;
        chk("ld_c0_b_out", 16'(ob), 16'h08);
        chk("ld_c0_b_state", 16'(st_b), 16'h0);
        chk("ld_c0_a_out", 16'(oa), 16'h08);
        tick(); clr_in(); #3;
        chk("ld_c1_b_out", 16'(ob), 16'h08);
        chk("ld_c1_b_state", 16'(st_b), 16'h1);
        chk("ld_c1_a_out", 16'(oa), 16'h60);
        tick(); #3;
        chk("ld_c2_b_out", 16'(ob), 16'h08);
        chk("ld_c2_b_state", 16'(st_b), 16'h1);
        tick(); #3;
        chk("ld_c3_b_out", 16'(ob), 16'h60);
        chk("ld_c3_b_state", 16'(st_b), 16'h0);
`ifndef HAZARD_PERF_CNT_EN
        chk("perf_tied_off", sc_b, 16'h0);
`else
        chk("perf_stall_cnt", sc_b, 16'd3);
`endif

        // mul/div with md_done five cycles after md_start (dut_a)
        do_reset();
        md_start = 1'b1;
        #3;
        chk("md_c0_out", 16'(oa), 16'h07);
        chk("md_c0_state", 16'(st_a), 16'h0);
        tick(); md_start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #3;
            chk($sformatf("md_c%0d_out", c), 16'(oa), 16'h06);
            chk($sformatf("md_c%0d_state", c), 16'(st_a), 16'h2);
            tick();
        end
        md_done = 1'b1;
        #3;
        chk("md_done_out", 16'(oa), 16'h00);
        tick(); md_done = 1'b0; #3;
        chk("md_after_out", 16'(oa), 16'h60);
        chk("md_after_state", 16'(st_a), 16'h0);
        chk("md_after_timeout", 16'(to_a), 16'h0);

        // timeout on dut_b (MD_TIMEOUT=4), md_done never arrives
        do_reset();
        md_start = 1'b1;
        tick(); md_start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            #3;
            chk($sformatf("to_c%0d_hold", c), 16'(eh_b), 16'h1);
            chk($sformatf("to_c%0d_state", c), 16'(st_b), 16'h2);
            tick();
        end
        #3;
        chk("to_c4_out", 16'(ob), 16'h00);
        chk("to_c4_flag", 16'(to_b), 16'h0);
        tick(); #3;
        chk("to_c5_state", 16'(st_b), 16'h0);
        chk("to_c5_flag", 16'(to_b), 16'h1);
        chk("to_c5_out", 16'(ob), 16'h60);
        md_done = 1'b1;
        tick(); tick(); md_done = 1'b0; tick(); #3;
        chk("to_sticky", 16'(to_b), 16'h1);
        rst_n = 1'b0;
        #1;
        chk("to_cleared", 16'(to_b), 16'h0);
        tick(); rst_n = 1'b1;

        // md_done on the timeout cycle wins: no timeout flag
        md_start = 1'b1;
        tick(); md_start = 1'b0;
        tick(); tick(); tick();
        md_done = 1'b1;
        #3;
        chk("race_out", 16'(ob), 16'h00);
        tick(); md_done = 1'b0; #3;
        chk("race_flag", 16'(to_b), 16'h0);
        chk("race_state", 16'(st_b), 16'h0);

        // async reset in the middle of MD_WAIT with hazards still asserted
        do_reset();
        md_start = 1'b1;
        tick(); md_start = 1'b0;
        tick(); #3;
        chk("mid_state_pre", 16'(st_a), 16'h2);
        ex_branch_taken = 1'b1; md_start = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", 16'(st_a), 16'h0);
        chk("mid_rst_out_a", 16'(oa), 16'h60);
        chk("mid_rst_out_b", 16'(ob), 16'h60);
        chk("mid_rst_stall", 16'(sc_a), 16'h0);
        tick(); clr_in(); rst_n = 1'b1;
        tick(); #3;
        chk("mid_post_state", 16'(st_a), 16'h0);
        chk("mid_post_out", 16'(oa), 16'h60);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
